cpu_fetch: RTL and testbench

//  Pipeline stage 1a. Fetches 32-bit words from instruction memory into a halfword

---
 rtl/cpu_fetch_pkg.sv | 22 ++
 rtl/cpu_fetch_hwq.sv | 101 ++++++++++
 rtl/cpu_fetch.sv | 167 ++++++++++++++++
 tb/tb_cpu_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch/decode definitions: instruction geometry, NOP encoding,
// pc step and the request FSM state type.
package cpu_fetch_pkg;

   localparam int INSN_W = 48;
   localparam int HW_W   = 16;

   localparam logic [7:0]        OPC_NOP      = 8'h00;
   localparam logic [INSN_W-1:0] NOP_INSN_DEF = {OPC_NOP, 40'h00_0000_0000};

   // Every instruction is three halfwords; the step is even, so pc bit 0
   // (the JS-mode flag) is never disturbed by an advance.
   localparam logic [31:0] PC_INC = 32'd6;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,   // no read in flight, waiting for queue space
      FS_REQ  = 2'd1,   // im__req raised, waiting for im__gnt
      FS_WAIT = 2'd2,   // read granted, waiting for im__valid
      FS_DROP = 2'd3    // read granted before a redirect; its data is discarded
   } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_hwq.sv
// Circular halfword prefetch queue. Pushes one or two halfwords per cycle,
// pops exactly three (one instruction) per cycle, and can be flushed.
// Exposes the fill count and the three halfwords at the head.
module cpu_fetch_hwq
   import cpu_fetch_pkg::*;
#(
   parameter int Q_HW = 8,
   parameter int CW   = $clog2(Q_HW + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic [1:0]      push_n,
   input  logic [HW_W-1:0] push_hw0,
   input  logic [HW_W-1:0] push_hw1,
   input  logic            pop3,
   output logic [CW-1:0]   count,
   output logic [HW_W-1:0] head0,
   output logic [HW_W-1:0] head1,
   output logic [HW_W-1:0] head2
);

   localparam int PW = $clog2(Q_HW);
   localparam logic [CW-1:0] CNT0 = CW'(2'd0);
   localparam logic [CW-1:0] CNT3 = CW'(2'd3);

   logic [HW_W-1:0] mem_q [Q_HW];
   logic [HW_W-1:0] mem_d [Q_HW];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            pop_ok_s;

   // Modular pointer step; also correct for even depths that are not a power of two.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [1:0] n);
      logic [PW:0] sum;
      sum = {1'b0, ptr} + (PW+1)'(n);
      if (sum >= (PW+1)'(Q_HW)) begin
         sum = sum - (PW+1)'(Q_HW);
      end else begin
         sum = sum;
      end
      return sum[PW-1:0];
   endfunction

   // A pop never removes more than is buffered.
   assign pop_ok_s = pop3 && (count_q >= CNT3);

   assign count = count_q;
   assign head0 = mem_q[head_q];
   assign head1 = mem_q[ptr_add(head_q, 2'd1)];
   assign head2 = mem_q[ptr_add(head_q, 2'd2)];

   // Next-state for storage, pointers and count; flush wins over push/pop.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = {PW{1'b0}};
         tail_d  = {PW{1'b0}};
         count_d = CNT0;
      end else begin
         case (push_n)
            2'd2: begin
               mem_d[tail_q]                 = push_hw0;
               mem_d[ptr_add(tail_q, 2'd1)]  = push_hw1;
            end
            2'd1: begin
               mem_d[tail_q] = push_hw0;
            end
            default: begin
               mem_d = mem_q;
            end
         endcase
         tail_d  = ptr_add(tail_q, push_n);
         head_d  = pop_ok_s ? ptr_add(head_q, 2'd3) : head_q;
         // Simultaneous pop and push: old - 3 + enqueued.
         count_d = count_q + CW'(push_n) - (pop_ok_s ? CNT3 : CNT0);
      end
   end

   // Queue registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < Q_HW; i++) begin
            mem_q[i] <= {HW_W{1'b0}};
         end
         head_q  <= {PW{1'b0}};
         tail_q  <= {PW{1'b0}};
         count_q <= CNT0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/cpu_fetch.sv
// Stage 1a instruction fetch: single-outstanding memory reader feeding a
// halfword queue, 48-bit instruction assembly, pc tracking and redirect.
module cpu_fetch
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0]       RESET_PC = 32'h0000_0000,
   parameter int                Q_HW     = 8,
   parameter logic [INSN_W-1:0] NOP_INSN = NOP_INSN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_2a,
   input  logic              kill_4a,
   input  logic [31:0]       br__target_4a,
   output logic              im__req,
   output logic [31:0]       im__addr,
   input  logic              im__gnt,
   input  logic              im__valid,
   input  logic [31:0]       im__rdata,
   output logic [INSN_W-1:0] instruction_1a,
   output logic [31:0]       pc_1a
);

   localparam int CW = $clog2(Q_HW + 1);
   localparam logic [CW-1:0] CNT3     = CW'(2'd3);
   localparam logic [CW-1:0] FREE_LIM = CW'(Q_HW - 2);

   fetch_state_e state_q, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  pc_q, pc_d;
   logic         skip_q, skip_d;

   logic [CW-1:0]   q_count_s;
   logic [HW_W-1:0] q_h0_s, q_h1_s, q_h2_s;
   logic            q_valid_s;
   logic            free_ok_s;
   logic            advance_s;
   logic            data_take_s;
   logic [1:0]      push_n_s;
   logic [HW_W-1:0] push_hw0_s;

   cpu_fetch_hwq #(.Q_HW(Q_HW), .CW(CW)) u_hwq (
      .clk      (clk),
      .rst      (rst),
      .flush    (kill_4a),
      .push_n   (push_n_s),
      .push_hw0 (push_hw0_s),
      .push_hw1 (im__rdata[15:0]),
      .pop3     (advance_s),
      .count    (q_count_s),
      .head0    (q_h0_s),
      .head1    (q_h1_s),
      .head2    (q_h2_s)
   );

   // Queue status. The registered count is already post-pop, and it can only
   // shrink while a read is in flight, so two free slots at request time
   // guarantee room for the returned word.
   assign q_valid_s = (q_count_s >= CNT3);
   assign free_ok_s = (q_count_s <= FREE_LIM);
   assign advance_s = !kill_4a && !stall_2a && q_valid_s;

   // Returned data is accepted only for a live read and never in a kill cycle.
   assign data_take_s = im__valid && (state_q == FS_WAIT) && !kill_4a;
   assign push_hw0_s  = skip_q ? im__rdata[15:0] : im__rdata[31:16];

   // Memory-side outputs are decoded straight from registers.
   assign im__req  = (state_q == FS_REQ);
   assign im__addr = addr_q;

   assign instruction_1a = q_valid_s ? {q_h0_s, q_h1_s, q_h2_s} : NOP_INSN;
   assign pc_1a          = pc_q;

   // Number of halfwords enqueued this cycle: the upper one is skipped after
   // a redirect into the middle of a word.
   always_comb begin
      push_n_s = 2'd0;
      if (data_take_s) begin
         push_n_s = skip_q ? 2'd1 : 2'd2;
      end else begin
         push_n_s = 2'd0;
      end
   end

   // Request FSM next state, fetch address and skip flag; a redirect overrides
   // the address and skip regardless of state.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      skip_d  = skip_q;
      case (state_q)
         FS_IDLE: begin
            if (!kill_4a && free_ok_s) begin
               state_d = FS_REQ;
            end else begin
               state_d = FS_IDLE;
            end
         end
         FS_REQ: begin
            if (im__gnt) begin
               addr_d  = addr_q + 32'd4;
               state_d = kill_4a ? FS_DROP : FS_WAIT;
            end else begin
               state_d = FS_REQ;
            end
         end
         FS_WAIT: begin
            if (im__valid) begin
               state_d = FS_IDLE;
            end else if (kill_4a) begin
               state_d = FS_DROP;
            end else begin
               state_d = FS_WAIT;
            end
         end
         FS_DROP: begin
            if (im__valid) begin
               state_d = FS_IDLE;
            end else begin
               state_d = FS_DROP;
            end
         end
         default: begin
            state_d = FS_IDLE;
         end
      endcase
      if (data_take_s) begin
         skip_d = 1'b0;
      end else begin
         skip_d = skip_q;
      end
      if (kill_4a) begin
         addr_d = {br__target_4a[31:2], 2'b00};
         skip_d = br__target_4a[1];
      end else begin
         addr_d = addr_d;
      end
   end

   // Program counter: redirect first, then advance on a consumed instruction.
   always_comb begin
      pc_d = pc_q;
      if (kill_4a) begin
         pc_d = br__target_4a;
      end else if (advance_s) begin
         pc_d = pc_q + PC_INC;
      end else begin
         pc_d = pc_q;
      end
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FS_IDLE;
         addr_q  <= {RESET_PC[31:2], 2'b00};
         skip_q  <= RESET_PC[1];
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         skip_q  <= skip_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: a memory model with programmable latency,
// a stimulus process that pushes expected (pc, instruction) pairs and
// granted addresses, and a monitor that pops and compares them.
module tb_cpu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_2a;
   logic        kill_4a;
   logic [31:0] br__target_4a;
   logic        im__req;
   logic [31:0] im__addr;
   logic        im__gnt;
   logic        im__valid;
   logic [31:0] im__rdata;
   logic [47:0] instruction_1a;
   logic [31:0] pc_1a;

   localparam logic [47:0] NOP = 48'h0;

   always #5 clk = ~clk;

   cpu_fetch #(.RESET_PC(32'h0000_0000), .Q_HW(8), .NOP_INSN(48'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_2a       (stall_2a),
      .kill_4a        (kill_4a),
      .br__target_4a  (br__target_4a),
      .im__req        (im__req),
      .im__addr       (im__addr),
      .im__gnt        (im__gnt),
      .im__valid      (im__valid),
      .im__rdata      (im__rdata),
      .instruction_1a (instruction_1a),
      .pc_1a          (pc_1a)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [47:0] insn;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] exp_addr_q[$];
   int total_cnt = 0;
   int pass_cnt  = 0;
   int gnt_min = 0, gnt_max = 0, val_min = 1, val_max = 1;

   // Memory contents: halfword at byte address a.
   function automatic logic [15:0] hw_at(input logic [31:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   function automatic logic [47:0] insn_at(input logic [31:0] pc);
      logic [31:0] a;
      a = {pc[31:1], 1'b0};
      return {hw_at(a), hw_at(a + 32'd2), hw_at(a + 32'd4)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic push_exp(input logic [31:0] pc0, input int n);
      logic [31:0] p;
      p = pc0;
      for (int i = 0; i < n; i++) begin
         sb_q.push_back('{pc: p, insn: insn_at(p)});
         p = p + 32'd6;
      end
   endtask

   task automatic push_lit(input logic [31:0] pc, input logic [47:0] insn);
      sb_q.push_back('{pc: pc, insn: insn});
   endtask

   // Run until every expected instruction is consumed, then freeze decode.
   task automatic wait_drain(input int budget, input bit rand_stall);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk);
         if (rand_stall) stall_2a = ($urandom_range(0, 2) == 0);
         #4;
         n++;
      end
      check("drain_left", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
      @(negedge clk);
      stall_2a = 1'b1;
   endtask

   task automatic wait_gnt(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         #4;
         seen = im__req && im__gnt;
      end
      check("gnt_seen", 64'(seen), 64'd1);
   endtask

   // Memory model: grants after a programmable delay, returns data later.
   initial begin : mem_model
      int gdly, vcnt;
      bit pend;
      logic [31:0] paddr;
      im__gnt = 1'b0; im__valid = 1'b0; im__rdata = 32'h0;
      gdly = 0; vcnt = 0; pend = 1'b0; paddr = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         im__gnt   = 1'b0;
         im__valid = 1'b0;
         if (rst) begin
            pend = 1'b0;
            gdly = 0;
         end else begin
            if (pend) begin
               vcnt--;
               if (vcnt == 0) begin
                  im__valid = 1'b1;
                  im__rdata = {hw_at(paddr), hw_at(paddr + 32'd2)};
                  pend = 1'b0;
               end
            end
            if (im__req && !pend) begin
               if (gdly == 0) begin
                  im__gnt = 1'b1;
                  paddr   = im__addr;
                  pend    = 1'b1;
                  vcnt    = $urandom_range(val_max, val_min);
                  gdly    = $urandom_range(gnt_max, gnt_min);
               end else begin
                  gdly--;
               end
            end
         end
      end
   end

   // Monitor: consumed instructions, granted addresses, stall/bubble stability.
   initial begin : monitor
      bit hold_v, hold_insn;
      logic [31:0] h_pc;
      logic [47:0] h_insn;
      exp_t e;
      hold_v = 1'b0; hold_insn = 1'b0; h_pc = 32'h0; h_insn = 48'h0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               check("hold_pc", 64'(pc_1a), 64'(h_pc));
               if (hold_insn) check("hold_insn", 64'(instruction_1a), 64'(h_insn));
            end
            if (im__req && im__gnt && exp_addr_q.size() > 0)
               check("im_addr", 64'(im__addr), 64'(exp_addr_q.pop_front()));
            if (!kill_4a && !stall_2a && instruction_1a != NOP) begin
               if (sb_q.size() == 0) begin
                  total_cnt++;
                  $display("FAIL unexpected_insn: got pc %h insn %h, expected none", pc_1a, instruction_1a);
               end else begin
                  e = sb_q.pop_front();
                  check("insn", 64'(instruction_1a), 64'(e.insn));
                  check("pc", 64'(pc_1a), 64'(e.pc));
               end
            end
            hold_v    = !kill_4a && (stall_2a || instruction_1a == NOP);
            hold_insn = stall_2a && instruction_1a != NOP;
            h_pc      = pc_1a;
            h_insn    = instruction_1a;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus.
   initial begin : stim
      rst = 1'b1; stall_2a = 1'b0; kill_4a = 1'b0; br__target_4a = 32'h0;
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h4);
      exp_addr_q.push_back(32'h8);
      exp_addr_q.push_back(32'hC);
      repeat (3) @(negedge clk);
      #4;
      check("rst_req", 64'(im__req), 64'd0);
      check("rst_pc", 64'(pc_1a), 64'h0);
      check("rst_insn", 64'(instruction_1a), 64'(NOP));

      // 1: straight-line fetch from reset with a 1-cycle memory.
      @(negedge clk);
      rst = 1'b0;
      push_exp(32'h0, 6);
      wait_drain(400, 1'b0);

      // 2: long stall, queue fills and requests stop; then resume.
      repeat (20) @(negedge clk);
      #4;
      check("stall_req_low", 64'(im__req), 64'd0);
      push_exp(32'd36, 6);
      @(negedge clk);
      stall_2a = 1'b0;
      wait_drain(400, 1'b0);

      // 3: redirect to 0x102 while a read is outstanding.
      val_min = 3; val_max = 3;
      @(negedge clk);
      kill_4a = 1'b1; br__target_4a = 32'h300;
      @(negedge clk);
      kill_4a = 1'b0;
      wait_gnt(100);
      @(negedge clk);
      kill_4a = 1'b1; br__target_4a = 32'h102;
      exp_addr_q.push_back(32'h100);
      push_lit(32'h102, 48'hC2A7_C2A1_C2A3);
      push_exp(32'h108, 3);
      @(negedge clk);
      kill_4a = 1'b0; stall_2a = 1'b0;
      wait_drain(400, 1'b0);

      // 4: redirect into JS mode; bit 0 survives advances.
      val_min = 1; val_max = 1;
      @(negedge clk);
      kill_4a = 1'b1; br__target_4a = 32'h201;
      push_lit(32'h201, 48'hC1A5_C1A7_C1A1);
      push_lit(32'h207, 48'hC1A3_C1AD_C1AF);
      push_lit(32'h20D, 48'hC1A9_C1AB_C1B5);
      @(negedge clk);
      kill_4a = 1'b0; stall_2a = 1'b0;
      wait_drain(400, 1'b0);

      // 5: random latencies and random stall, aligned and mid-word targets.
      gnt_min = 0; gnt_max = 4; val_min = 1; val_max = 5;
      @(negedge clk);
      kill_4a = 1'b1; br__target_4a = 32'h40;
      push_exp(32'h40, 25);
      @(negedge clk);
      kill_4a = 1'b0;
      wait_drain(3000, 1'b1);
      @(negedge clk);
      kill_4a = 1'b1; br__target_4a = 32'h8E;
      push_exp(32'h8E, 12);
      @(negedge clk);
      kill_4a = 1'b0;
      wait_drain(3000, 1'b1);

      // 6: reset while a read is in flight.
      gnt_min = 0; gnt_max = 0; val_min = 3; val_max = 3;
      @(negedge clk);
      kill_4a = 1'b1; br__target_4a = 32'h10;
      @(negedge clk);
      kill_4a = 1'b0;
      wait_gnt(100);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #4;
      check("midrst_pc", 64'(pc_1a), 64'h0);
      check("midrst_req", 64'(im__req), 64'd0);
      check("midrst_insn", 64'(instruction_1a), 64'(NOP));
      repeat (2) @(negedge clk);
      check("addr_left", 64'(exp_addr_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
